car_mode_ctrl: RTL and testbench
================================

// Module: car_mode_ctrl
// PURPOSE
//  Top-level motion scheduler for the smart car. Takes the classified IR codes
//  (mode / speed / move bytes plus a strobe) and decides which source owns the
//  motors: IR remote, line tracker, follower or ultrasonic avoider. Inserts a
//  brake interval on every mode switch, runs a remote-command watchdog and
//  soft-ramps PWM duty. Output feeds the motor PWM / H-bridge driver.
// PARAMETERS
//  SW_STOP_CYC  5_000_000  brake cycles on mode switch (100 ms @ 50 MHz), >=1
//  CMD_TIMEOUT  25_000_000 remote mode: cycles without move code before auto-stop
//  RAMP_DIV     50_000     cycles between duty ramp steps, >=1
//  RAMP_STEP    8'd8       duty increment per ramp step
//  DUTY_LO/MID/HI 8'd100 / 8'd170 / 8'd255  duty for speed codes 22 / 25 / 13
// PORTS
//  sys_clk     in  1  system clock
//  sys_rst_n   in  1  asynchronous reset, active low
//  ir_vld      in  1  1-cycle strobe; data_* below are valid this cycle
//  data_mode   in  8  mode code: 69 remote, 70 track, 71 follow, 68 avoid
//  data_pwm    in  8  speed code: 22 low, 25 mid, 13 high
//  data_move   in  8  move code: 24 fwd, 8 left, 90 right, 82 back, 28 stop
//  trk_dir     in  3  line-tracker direction request (dir encoding below)
//  flw_dir     in  3  follower direction request
//  avd_dir     in  3  avoider direction request
//  mode_state  out 2  active mode: 0 remote, 1 track, 2 follow, 3 avoid
//  ctrl_state  out 2  FSM: 0 IDLE, 1 BRAKE, 2 RUN
//  motor_dir   out 3  0 STOP, 1 FWD, 2 BACK, 3 LEFT, 4 RIGHT (5-7 treated STOP)
//  duty        out 8  PWM duty to motor driver
// BEHAVIOUR
//  Reset: ctrl_state=IDLE, mode_state=0, motor_dir=STOP, duty=0, speed target
//   =DUTY_MID, remote dir=STOP, all counters 0.
//  All decisions on ir_vld; outputs registered, effect visible cycle after ir_vld.
//  Per ir_vld, data_mode/pwm/move each examined; unknown values ignored.
//  FSM:
//   IDLE : motor_dir=STOP, duty=0. Valid mode code -> latch target mode, BRAKE.
//   BRAKE: motor_dir=STOP, duty=0, counter counts SW_STOP_CYC cycles, then
//          mode_state<=target, RUN. New different mode code during BRAKE:
//          retarget and restart counter. Same code: no effect.
//   RUN  : mode code == mode_state: ignored. Different valid mode -> BRAKE.
//  mode_state updates only on BRAKE->RUN exit (holds old mode during BRAKE).
//  Direction source in RUN: remote -> remote dir reg; track/follow/avoid ->
//   trk_dir/flw_dir/avd_dir sampled every cycle; codes 5-7 -> STOP.
//  Remote dir reg: move code sets it (28 -> STOP) and clears watchdog; cleared to
//   STOP on entry to remote RUN. Move codes ignored in other modes. Watchdog
//   counts in remote RUN while dir!=STOP; reaching CMD_TIMEOUT -> dir=STOP.
//   Move code on same cycle as expiry wins (dir set, watchdog cleared).
//  Speed code updates target duty in any state; takes effect via ramp.
//  Duty ramp: any motor_dir change or STOP forces duty=0 and clears ramp
//   counter. While dir!=STOP: every RAMP_DIV cycles duty+=RAMP_STEP, saturating
//   at target (no overshoot, no 8-bit wrap). Target lowered below duty: duty
//   drops to target on next step tick.
//  Mode code and speed code in same ir_vld: both applied.
// TESTING
//  (sim params SW_STOP_CYC=4, CMD_TIMEOUT=20, RAMP_DIV=2, RAMP_STEP=50)
//  Reset -> ctrl_state=0, motor_dir=0, duty=0; mode 69 -> BRAKE 4 cycles, RUN, mode_state=0.
//  Remote RUN, move 24 -> motor_dir=1, duty 0,50,100,150,170 (held) every 2 cycles.
//  No further ir_vld -> motor_dir=0, duty=0 exactly 20 cycles after last move code.
//  RUN track, trk_dir=3, mode 68 -> immediate STOP/duty 0, 4 brake cycles, mode_state=3, dir=avd_dir.
//  During BRAKE to 70, send 71 -> counter restarts, RUN with mode_state=2; 70 again ignored.
//  Speed 13 while duty=170 -> ramps 220,255 then holds; speed 22 -> duty=100 next tick.

Source files
------------

// File: rtl/car_mode_ctrl.sv
// -----------------------------------------------------------------------------
// car_mode_ctrl
//   Motion scheduler for the smart car. Decides which source owns the motors
//   (IR remote, line tracker, follower, ultrasonic avoider), inserts a brake
//   interval on every mode switch, runs a remote-command watchdog and
//   soft-ramps the PWM duty handed to the H-bridge driver.
//
// Ports
//   sys_clk    in   1  system clock
//   sys_rst_n  in   1  asynchronous reset, active low
//   ir_vld     in   1  one-cycle strobe, data_* valid this cycle
//   data_mode  in   8  mode code: 69 remote, 70 track, 71 follow, 68 avoid
//   data_pwm   in   8  speed code: 22 low, 25 mid, 13 high
//   data_move  in   8  move code: 24 fwd, 8 left, 90 right, 82 back, 28 stop
//   trk_dir    in   3  line-tracker direction request
//   flw_dir    in   3  follower direction request
//   avd_dir    in   3  avoider direction request
//   mode_state out  2  active mode: 0 remote, 1 track, 2 follow, 3 avoid
//   ctrl_state out  2  0 IDLE, 1 BRAKE, 2 RUN
//   motor_dir  out  3  0 STOP, 1 FWD, 2 BACK, 3 LEFT, 4 RIGHT
//   duty       out  8  PWM duty to motor driver
// -----------------------------------------------------------------------------
module car_mode_ctrl #(
  parameter int unsigned SW_STOP_CYC = 5_000_000,
  parameter int unsigned CMD_TIMEOUT = 25_000_000,
  parameter int unsigned RAMP_DIV    = 50_000,
  parameter logic [7:0]  RAMP_STEP   = 8'd8,
  parameter logic [7:0]  DUTY_LO     = 8'd100,
  parameter logic [7:0]  DUTY_MID    = 8'd170,
  parameter logic [7:0]  DUTY_HI     = 8'd255
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       ir_vld,
  input  logic [7:0] data_mode,
  input  logic [7:0] data_pwm,
  input  logic [7:0] data_move,
  input  logic [2:0] trk_dir,
  input  logic [2:0] flw_dir,
  input  logic [2:0] avd_dir,
  output logic [1:0] mode_state,
  output logic [1:0] ctrl_state,
  output logic [2:0] motor_dir,
  output logic [7:0] duty
);

  typedef enum logic [1:0] {IDLE = 2'd0, BRAKE = 2'd1, RUN = 2'd2} ctrl_e;
  typedef enum logic [1:0] {M_REMOTE = 2'd0, M_TRACK = 2'd1, M_FOLLOW = 2'd2, M_AVOID = 2'd3} mode_e;

  localparam logic [2:0] D_STOP  = 3'd0;
  localparam logic [2:0] D_FWD   = 3'd1;
  localparam logic [2:0] D_BACK  = 3'd2;
  localparam logic [2:0] D_LEFT  = 3'd3;
  localparam logic [2:0] D_RIGHT = 3'd4;

  // Counters run 0..N-1, so they need clog2(N) bits (at least one).
  localparam int BRK_W = (SW_STOP_CYC > 1) ? $clog2(SW_STOP_CYC) : 1;
  localparam int WD_W  = (CMD_TIMEOUT > 1) ? $clog2(CMD_TIMEOUT) : 1;
  localparam int RMP_W = (RAMP_DIV    > 1) ? $clog2(RAMP_DIV)    : 1;
  localparam logic [BRK_W-1:0] BRK_LAST = BRK_W'(SW_STOP_CYC - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(CMD_TIMEOUT - 1);
  localparam logic [RMP_W-1:0] RMP_LAST = RMP_W'(RAMP_DIV - 1);

  ctrl_e            state_q,   state_d;
  mode_e            mode_q,    mode_d;
  mode_e            target_q,  target_d;
  logic [BRK_W-1:0] brk_cnt_q, brk_cnt_d;
  logic [2:0]       rem_dir_q, rem_dir_d;
  logic [WD_W-1:0]  wd_cnt_q,  wd_cnt_d;
  logic [7:0]       spd_tgt_q, spd_tgt_d;
  logic [RMP_W-1:0] rmp_cnt_q, rmp_cnt_d;
  logic [2:0]       dir_q,     dir_d;
  logic [7:0]       duty_q,    duty_d;

  // Code decoders; unknown codes simply never raise their hit flag.
  logic       mode_hit, pwm_hit, move_hit;
  mode_e      mode_code;
  logic [7:0] pwm_duty;
  logic [2:0] move_dir;
  logic [8:0] duty_sum;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    mode_hit  = ir_vld;
    mode_code = M_REMOTE;
    case (data_mode)
      8'd69:   mode_code = M_REMOTE;
      8'd70:   mode_code = M_TRACK;
      8'd71:   mode_code = M_FOLLOW;
      8'd68:   mode_code = M_AVOID;
      default: mode_hit  = 1'b0;
    endcase

    pwm_hit  = ir_vld;
    pwm_duty = DUTY_MID;
    case (data_pwm)
      8'd22:   pwm_duty = DUTY_LO;
      8'd25:   pwm_duty = DUTY_MID;
      8'd13:   pwm_duty = DUTY_HI;
      default: pwm_hit  = 1'b0;
    endcase

    move_hit = ir_vld;
    move_dir = D_STOP;
    case (data_move)
      8'd24:   move_dir = D_FWD;
      8'd8:    move_dir = D_LEFT;
      8'd90:   move_dir = D_RIGHT;
      8'd82:   move_dir = D_BACK;
      8'd28:   move_dir = D_STOP;
      default: move_hit = 1'b0;
    endcase
  end

  // Mode FSM: brake on every switch, commit mode_state only on brake exit.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    target_d  = target_q;
    brk_cnt_d = brk_cnt_q;
    case (state_q)
      IDLE: begin
        if (mode_hit) begin
          target_d  = mode_code;
          brk_cnt_d = '0;
          state_d   = BRAKE;
        end
      end
      BRAKE: begin
        // A retarget takes priority over the brake expiring on the same cycle.
        if (mode_hit && (mode_code != target_q)) begin
          target_d  = mode_code;
          brk_cnt_d = '0;
        end else if (brk_cnt_q == BRK_LAST) begin
          brk_cnt_d = '0;
          mode_d    = target_q;
          state_d   = RUN;
        end else begin
          brk_cnt_d = brk_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (mode_hit && (mode_code != mode_q)) begin
          target_d  = mode_code;
          brk_cnt_d = '0;
          state_d   = BRAKE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Remote direction register and its command watchdog.
  always_comb begin
    rem_dir_d = rem_dir_q;
    wd_cnt_d  = wd_cnt_q;
    if ((state_q == BRAKE) && (state_d == RUN) && (target_q == M_REMOTE)) begin
      rem_dir_d = D_STOP;
      wd_cnt_d  = '0;
    end else if ((state_q == RUN) && (mode_q == M_REMOTE)) begin
      if (move_hit) begin
        rem_dir_d = move_dir;
        wd_cnt_d  = '0;
      end else if (rem_dir_q != D_STOP) begin
        if (wd_cnt_q == WD_LAST) begin
          rem_dir_d = D_STOP;
          wd_cnt_d  = '0;
        end else begin
          wd_cnt_d  = wd_cnt_q + 1'b1;
        end
      end
    end
  end

  // Direction and duty ramp are computed from next-state values so that the
  // registered outputs change on the same edge that samples ir_vld.
  always_comb begin
    spd_tgt_d = pwm_hit ? pwm_duty : spd_tgt_q;

    dir_d = D_STOP;
    if (state_d == RUN) begin
      case (mode_d)
        M_REMOTE: dir_d = rem_dir_d;
        M_TRACK:  dir_d = trk_dir;
        M_FOLLOW: dir_d = flw_dir;
        M_AVOID:  dir_d = avd_dir;
        default:  dir_d = D_STOP;
      endcase
    end
    if (dir_d > D_RIGHT) dir_d = D_STOP;

    // Saturate against the target in 9 bits: no 8-bit wrap, and a lowered
    // target pulls duty straight down on the next step tick.
    duty_sum  = {1'b0, duty_q} + {1'b0, RAMP_STEP};
    duty_d    = duty_q;
    rmp_cnt_d = rmp_cnt_q;
    if ((dir_d == D_STOP) || (dir_d != dir_q)) begin
      duty_d    = '0;
      rmp_cnt_d = '0;
    end else if (rmp_cnt_q == RMP_LAST) begin
      rmp_cnt_d = '0;
      duty_d    = (duty_sum >= {1'b0, spd_tgt_q}) ? spd_tgt_q : duty_sum[7:0];
    end else begin
      rmp_cnt_d = rmp_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      mode_q    <= M_REMOTE;
      target_q  <= M_REMOTE;
      brk_cnt_q <= '0;
      rem_dir_q <= D_STOP;
      wd_cnt_q  <= '0;
      spd_tgt_q <= DUTY_MID;
      rmp_cnt_q <= '0;
      dir_q     <= D_STOP;
      duty_q    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state_q   <= state_d;
      mode_q    <= mode_d;
      target_q  <= target_d;
      brk_cnt_q <= brk_cnt_d;
      rem_dir_q <= rem_dir_d;
      wd_cnt_q  <= wd_cnt_d;
      spd_tgt_q <= spd_tgt_d;
      rmp_cnt_q <= rmp_cnt_d;
      dir_q     <= dir_d;
      duty_q    <= duty_d;
    end
  end

  assign ctrl_state = state_q;
  assign mode_state = mode_q;
  assign motor_dir  = dir_q;
  assign duty       = duty_q;

endmodule

// File: tb/tb_car_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_car_mode_ctrl
//   Directed bench for car_mode_ctrl with short timing parameters
//   (brake 4, watchdog 20, ramp every 2 cycles by 50). Inputs change on the
//   falling edge; outputs are read on the falling edge, i.e. half a cycle after
//   the rising edge that updated them.
// -----------------------------------------------------------------------------
module tb_car_mode_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       ir_vld = 1'b0;
  logic [7:0] data_mode = '0, data_pwm = '0, data_move = '0;
  logic [2:0] trk_dir = '0, flw_dir = '0, avd_dir = '0;
  logic [1:0] mode_state, ctrl_state;
  logic [2:0] motor_dir;
  logic [7:0] duty;

  int checks   = 0;
  int failures = 0;

  car_mode_ctrl #(
    .SW_STOP_CYC(4),
    .CMD_TIMEOUT(20),
    .RAMP_DIV   (2),
    .RAMP_STEP  (8'd50),
    .DUTY_LO    (8'd100),
    .DUTY_MID   (8'd170),
    .DUTY_HI    (8'd255)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .ir_vld    (ir_vld),
    .data_mode (data_mode),
    .data_pwm  (data_pwm),
    .data_move (data_move),
    .trk_dir   (trk_dir),
    .flw_dir   (flw_dir),
    .avd_dir   (avd_dir),
    .mode_state(mode_state),
    .ctrl_state(ctrl_state),
    .motor_dir (motor_dir),
    .duty      (duty)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (got running, need finished)");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // One ir_vld pulse; returns on the falling edge after the sampling edge.
  task automatic send(input logic [7:0] m, input logic [7:0] p, input logic [7:0] mv);
    ir_vld = 1'b1; data_mode = m; data_pwm = p; data_move = mv;
    @(negedge sys_clk);
    ir_vld = 1'b0; data_mode = '0; data_pwm = '0; data_move = '0;
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    step(3);
    checks++; if (ctrl_state !== 2'd0) begin failures++; $display("FAIL reset ctrl_state got=%0d exp=0", ctrl_state); end
    checks++; if (mode_state !== 2'd0) begin failures++; $display("FAIL reset mode_state got=%0d exp=0", mode_state); end
    checks++; if (motor_dir !== 3'd0) begin failures++; $display("FAIL reset motor_dir got=%0d exp=0", motor_dir); end
    checks++; if (duty !== 8'd0) begin failures++; $display("FAIL reset duty got=%0d exp=0", duty); end
    sys_rst_n = 1'b1;
    step(2);
    checks++; if (ctrl_state !== 2'd0) begin failures++; $display("FAIL idle_hold ctrl_state got=%0d exp=0", ctrl_state); end
  endtask

  task automatic test_mode_entry;
    send(8'd69, 8'd0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (ctrl_state !== 2'd1) begin failures++; $display("FAIL entry_brake[%0d] ctrl_state got=%0d exp=1", i, ctrl_state); end
      checks++; if (motor_dir !== 3'd0 || duty !== 8'd0) begin failures++; $display("FAIL entry_brake[%0d] dir/duty got=%0d/%0d exp=0/0", i, motor_dir, duty); end
      step(1);
    end
    checks++; if (ctrl_state !== 2'd2) begin failures++; $display("FAIL entry_run ctrl_state got=%0d exp=2", ctrl_state); end
    checks++; if (mode_state !== 2'd0) begin failures++; $display("FAIL entry_run mode_state got=%0d exp=0", mode_state); end
    checks++; if (motor_dir !== 3'd0) begin failures++; $display("FAIL entry_run motor_dir got=%0d exp=0", motor_dir); end
  endtask

  task automatic test_remote_ramp_watchdog;
    logic [7:0] exp_duty;
    send(8'd0, 8'd0, 8'd24);
    for (int k = 0; k < 20; k++) begin
      exp_duty = ((k / 2) * 50 > 170) ? 8'd170 : 8'((k / 2) * 50);
      checks++; if (motor_dir !== 3'd1) begin failures++; $display("FAIL ramp[%0d] motor_dir got=%0d exp=1", k, motor_dir); end
      checks++; if (duty !== exp_duty) begin failures++; $display("FAIL ramp[%0d] duty got=%0d exp=%0d", k, duty, exp_duty); end
      step(1);
    end
    checks++; if (motor_dir !== 3'd0) begin failures++; $display("FAIL watchdog motor_dir got=%0d exp=0", motor_dir); end
    checks++; if (duty !== 8'd0) begin failures++; $display("FAIL watchdog duty got=%0d exp=0", duty); end
  endtask

  task automatic test_speed_change;
    logic [7:0] exp_hi [5];
    exp_hi = '{8'd220, 8'd220, 8'd255, 8'd255, 8'd255};
    send(8'd0, 8'd0, 8'd24);
    step(8);
    checks++; if (duty !== 8'd170) begin failures++; $display("FAIL speed_mid duty got=%0d exp=170", duty); end
    send(8'd0, 8'd13, 8'd0);
    checks++; if (duty !== 8'd170) begin failures++; $display("FAIL speed_hi_latch duty got=%0d exp=170", duty); end
    for (int i = 0; i < 5; i++) begin
      step(1);
      checks++; if (duty !== exp_hi[i]) begin failures++; $display("FAIL speed_hi[%0d] duty got=%0d exp=%0d", i, duty, exp_hi[i]); end
    end
    send(8'd0, 8'd22, 8'd0);
    checks++; if (duty !== 8'd255) begin failures++; $display("FAIL speed_lo_latch duty got=%0d exp=255", duty); end
    step(1);
    checks++; if (duty !== 8'd100) begin failures++; $display("FAIL speed_lo_drop duty got=%0d exp=100", duty); end
    send(8'd0, 8'd25, 8'd28);
    checks++; if (motor_dir !== 3'd0 || duty !== 8'd0) begin failures++; $display("FAIL move_stop dir/duty got=%0d/%0d exp=0/0", motor_dir, duty); end
  endtask

  task automatic test_track_to_avoid;
    trk_dir = 3'd3; avd_dir = 3'd4; flw_dir = 3'd1;
    // Mode and speed code in one strobe: both must take effect.
    send(8'd70, 8'd13, 8'd0);
    checks++; if (ctrl_state !== 2'd1 || mode_state !== 2'd0) begin failures++; $display("FAIL trk_brake ctrl/mode got=%0d/%0d exp=1/0", ctrl_state, mode_state); end
    step(4);
    checks++; if (ctrl_state !== 2'd2 || mode_state !== 2'd1) begin failures++; $display("FAIL trk_run ctrl/mode got=%0d/%0d exp=2/1", ctrl_state, mode_state); end
    checks++; if (motor_dir !== 3'd3 || duty !== 8'd0) begin failures++; $display("FAIL trk_run dir/duty got=%0d/%0d exp=3/0", motor_dir, duty); end
    step(10);
    checks++; if (duty !== 8'd250) begin failures++; $display("FAIL trk_ramp duty got=%0d exp=250", duty); end
    step(2);
    checks++; if (duty !== 8'd255) begin failures++; $display("FAIL trk_sat duty got=%0d exp=255", duty); end
    send(8'd68, 8'd25, 8'd0);
    checks++; if (motor_dir !== 3'd0 || duty !== 8'd0) begin failures++; $display("FAIL avd_switch dir/duty got=%0d/%0d exp=0/0", motor_dir, duty); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (ctrl_state !== 2'd1 || mode_state !== 2'd1) begin failures++; $display("FAIL avd_brake[%0d] ctrl/mode got=%0d/%0d exp=1/1", i, ctrl_state, mode_state); end
      step(1);
    end
    checks++; if (ctrl_state !== 2'd2 || mode_state !== 2'd3) begin failures++; $display("FAIL avd_run ctrl/mode got=%0d/%0d exp=2/3", ctrl_state, mode_state); end
    checks++; if (motor_dir !== 3'd4) begin failures++; $display("FAIL avd_run motor_dir got=%0d exp=4", motor_dir); end
    avd_dir = 3'd6;
    step(1);
    checks++; if (motor_dir !== 3'd0 || duty !== 8'd0) begin failures++; $display("FAIL avd_bad_code dir/duty got=%0d/%0d exp=0/0", motor_dir, duty); end
    avd_dir = 3'd2;
    step(1);
    checks++; if (motor_dir !== 3'd2 || duty !== 8'd0) begin failures++; $display("FAIL avd_back dir/duty got=%0d/%0d exp=2/0", motor_dir, duty); end
    step(2);
    checks++; if (duty !== 8'd50) begin failures++; $display("FAIL avd_ramp duty got=%0d exp=50", duty); end
  endtask

  task automatic test_retarget;
    send(8'd70, 8'd0, 8'd0);
    step(2);
    checks++; if (ctrl_state !== 2'd1) begin failures++; $display("FAIL rtg_brake ctrl_state got=%0d exp=1", ctrl_state); end
    send(8'd71, 8'd0, 8'd0);
    step(1);
    // Repeating the current target must not restart the brake counter.
    send(8'd71, 8'd0, 8'd0);
    step(1);
    checks++; if (ctrl_state !== 2'd1 || mode_state !== 2'd3) begin failures++; $display("FAIL rtg_restart ctrl/mode got=%0d/%0d exp=1/3", ctrl_state, mode_state); end
    step(1);
    checks++; if (ctrl_state !== 2'd2 || mode_state !== 2'd2) begin failures++; $display("FAIL rtg_run ctrl/mode got=%0d/%0d exp=2/2", ctrl_state, mode_state); end
    checks++; if (motor_dir !== 3'd1) begin failures++; $display("FAIL rtg_run motor_dir got=%0d exp=1", motor_dir); end
    // Same mode in RUN and a move code outside remote mode are both ignored.
    send(8'd71, 8'd0, 8'd24);
    checks++; if (ctrl_state !== 2'd2 || motor_dir !== 3'd1) begin failures++; $display("FAIL run_same ctrl/dir got=%0d/%0d exp=2/1", ctrl_state, motor_dir); end
    flw_dir = 3'd3;
    step(1);
    checks++; if (motor_dir !== 3'd3) begin failures++; $display("FAIL flw_follow motor_dir got=%0d exp=3", motor_dir); end
  endtask

  initial begin
    test_reset();
    test_mode_entry();
    test_remote_ramp_watchdog();
    test_speed_change();
    test_track_to_avoid();
    test_retarget();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
